// File: rtl/dram_rd_pkg.sv
// Shared types and defaults for the dram burst read front-end.
package dram_rd_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 18;
    localparam int LEN_W  = 12;
    localparam int FIFO_D = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    // Occupancy counters must hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dram_rd_sync_fifo.sv
// Power-of-two response buffer; head word is read straight from registered storage.
module sync_fifo
    import dram_rd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [cnt_w(DEPTH)-1:0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    // A pop frees the slot being written, so push at full is fine alongside it.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/dram_rd_ctrl.sv
// Burst read controller: credit-limited dram read issue, buffered in-order stream out.
module dram_rd_ctrl
    import dram_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int LEN_WIDTH  = LEN_W,
    parameter int FIFO_DEPTH = FIFO_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  dram_en_rd,
    output logic [ADDR_WIDTH-1:0] dram_addr_rd,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] dram_data_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done,
    output logic                  err
);

    localparam int CW = cnt_w(FIFO_DEPTH);

    state_e                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  en_rd_q, en_rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] nxt_addr_q, nxt_addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic [LEN_WIDTH-1:0]  popped_q, popped_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  credit_ok;
    logic [CW:0]           inflight;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (dram_data_rd),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign accept    = (state_q == IDLE) & req_valid & req_ready_q;
    assign push      = dram_valid & (outst_q != '0);
    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_head;
    assign out_last  = out_valid & ((popped_q + LEN_WIDTH'(1)) == len_q);
    assign pop       = out_valid & out_ready;

    // The strobe currently on the bus already owns a buffer slot.
    assign inflight  = {1'b0, outst_q} + (CW+1)'(en_rd_q) + {1'b0, fifo_count};
    assign credit_ok = ~fifo_full & (inflight < (CW+1)'(FIFO_DEPTH));

    assign req_ready    = req_ready_q;
    assign dram_en_rd   = en_rd_q;
    assign dram_addr_rd = addr_q;
    assign done         = done_q;
    assign err          = err_q;

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        en_rd_d     = 1'b0;
        addr_d      = addr_q;
        nxt_addr_d  = nxt_addr_q;
        len_d       = len_q;
        issued_d    = issued_q;
        popped_d    = popped_q + LEN_WIDTH'(pop);
        outst_d     = outst_q + CW'(en_rd_q) - CW'(push);
        done_d      = 1'b0;
        err_d       = err_q | (dram_valid & (outst_q == '0));

        unique case (state_q)
            IDLE: begin
                req_ready_d = ~accept;
                if (accept) begin
                    len_d      = req_len;
                    popped_d   = '0;
                    issued_d   = '0;
                    nxt_addr_d = req_addr;
                    if (req_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    done_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Covers both the acceptance cycle and steady issue.
        if (state_d == ISSUE && credit_ok) begin
            en_rd_d    = 1'b1;
            addr_d     = nxt_addr_d;
            nxt_addr_d = nxt_addr_d + ADDR_WIDTH'(1);
            issued_d   = issued_d + LEN_WIDTH'(1);
            if (issued_d == len_d) begin
                state_d = DRAIN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            en_rd_q     <= 1'b0;
            addr_q      <= '0;
            nxt_addr_q  <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            outst_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            en_rd_q     <= en_rd_d;
            addr_q      <= addr_d;
            nxt_addr_q  <= nxt_addr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            popped_q    <= popped_d;
            outst_q     <= outst_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule
